// File: rtl/uart_pkg.sv
// Shared UART definitions: TX frame FSM states, frame sizing and the parity helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } tx_state_t;

    localparam int unsigned MAX_FRAME_BITS = 12;
    localparam int unsigned FRAME_IDX_W    = $clog2(MAX_FRAME_BITS);

    typedef logic [FRAME_IDX_W-1:0] frame_idx_t;

    // XOR of the low nbits of data, inverted when odd parity is selected.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input int unsigned nbits,
                                        input logic odd);
        logic p;
        p = odd;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < nbits) p ^= data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// UART TX framer: accepts a byte, then issues start, data (LSB first), parity and stop bits
// one at a time to the bit-timing stage. Parity bit is present only with UART_TX_PARITY_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DataBits   = 8,
    parameter int unsigned StopBits   = 1,
    parameter logic        ParityOdd  = 1'b0,
    parameter int unsigned AckTimeout = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       bit_start,
    output logic       bit_value,
    input  logic       bit_done,
    output logic       busy,
    output logic       frame_done
);

`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    localparam int unsigned FL         = 1 + DataBits + PAR_BITS + StopBits;
    localparam frame_idx_t  LAST_IDX   = frame_idx_t'(FL - 1);
    localparam int unsigned TW         = $clog2(AckTimeout + 1);
    localparam logic [TW-1:0] ACK_LIMIT = TW'(AckTimeout);

    localparam logic [MAX_FRAME_BITS-1:0] DATA_MASK  = MAX_FRAME_BITS'((1 << DataBits) - 1);
    localparam logic [MAX_FRAME_BITS-1:0] STOP_FIELD =
        MAX_FRAME_BITS'(((1 << StopBits) - 1) << (1 + DataBits + PAR_BITS));

    tx_state_t                 state_q, state_d;
    logic [MAX_FRAME_BITS-1:0] frame_q, frame_d, frame_load;
    frame_idx_t                idx_q, idx_d;
    logic [TW-1:0]             tcount_q, tcount_d;
    logic                      done_q, done_d;
    logic                      complete;
    logic [MAX_FRAME_BITS-1:0] data_field;

    assign data_field = {4'b0000, data_in} & DATA_MASK;

    // Start bit is the zero left at bit 0 by the shift.
`ifdef UART_TX_PARITY_EN
    assign frame_load = (data_field << 1) | STOP_FIELD
                      | (MAX_FRAME_BITS'(parity_bit(data_in, DataBits, ParityOdd)) << (1 + DataBits));
`else
    logic unused_parity_odd;
    assign unused_parity_odd = ParityOdd;
    assign frame_load = (data_field << 1) | STOP_FIELD;
`endif

    assign data_ready = !reset && (state_q == IDLE) && bit_done;
    assign busy       = (state_q != IDLE);
    assign bit_value  = (state_q == IDLE) ? 1'b1 : frame_q[0];
    assign frame_done = done_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            idx_q    <= '0;
            tcount_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            idx_q    <= idx_d;
            tcount_q <= tcount_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        tcount_d  = tcount_q;
        done_d    = 1'b0;
        bit_start = 1'b0;
        complete  = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_valid && data_ready) begin
                    frame_d = frame_load;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                bit_start = 1'b1;
                tcount_d  = '0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                // A bit stage that never drops bit_done still completes after AckTimeout.
                if (!bit_done)                  state_d  = WAIT_DONE;
                else if (tcount_q == ACK_LIMIT) complete = 1'b1;
                else                            tcount_d = tcount_q + 1'b1;
            end
            WAIT_DONE: begin
                if (bit_done) complete = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            frame_d = frame_q >> 1;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = SEND;
            end
        end
    end

endmodule
